cyclic74_decoder: RTL and testbench

Serial (7,4) cyclic-code decoder with single-error correction. It sits directly downstream of the (7,4) cyclic encoder, which uses g(x)=1+x+x^3.
- Receives one codeword bit per accepted cycle, highest degree first.
- Computes the syndrome by polynomial division.
- Corrects at most one bit error.
- Presents the 4-bit message, the syndrome and error information on a valid/ready output.

---
 rtl/cyclic74_pkg.sv | 35 +++
 rtl/cyclic74_syndrome_lfsr.sv | 32 +++
 rtl/cyclic74_decoder.sv | 123 ++++++++++++
 tb/tb_cyclic74_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cyclic74_pkg.sv
// Shared definitions for the serial (7,4) cyclic-code decoder.
//   N, K, GPOLY : code geometry and generator g(x) = 1 + x + x^3 (g3..g0)
//   state_t     : decoder FSM states
//   syn2pos     : syndrome -> single-error bit position map
package cyclic74_pkg;

    localparam int unsigned N     = 7;
    localparam int unsigned K     = 4;
    localparam logic [3:0]  GPOLY = 4'b1011;

    typedef enum logic [1:0] {
        RX   = 2'd0,
        CORR = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Each entry is x^pos mod g(x) written as {s2,s1,s0}.
    // Every nonzero syndrome maps to exactly one position.
    function automatic logic [2:0] syn2pos(input logic [2:0] syn);
        logic [2:0] pos;
        pos = '0;
        case (syn)
            3'b001:  pos = 3'd0;
            3'b010:  pos = 3'd1;
            3'b100:  pos = 3'd2;
            3'b011:  pos = 3'd3;
            3'b110:  pos = 3'd4;
            3'b111:  pos = 3'd5;
            3'b101:  pos = 3'd6;
            default: pos = 3'd0;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/cyclic74_syndrome_lfsr.sv
// Serial polynomial divider by g(x) = 1 + x + x^3.
// After the received bits are shifted in highest degree first, syn holds
// r(x) mod g(x) as {s2,s1,s0}.
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   clear    : synchronous clear of the division register
//   shift_en : shift one received bit in this cycle
//   bit_in   : received bit
//   syn      : current remainder {s2,s1,s0}
module cyclic74_syndrome_lfsr
    import cyclic74_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       bit_in,
    output logic [2:0] syn
);

    // Feedback f = s2 is folded back at the x^1 and x^0 taps of g(x).
    always_ff @(posedge clk) begin
        if (!rst) begin
            syn <= '0;
        end else if (clear) begin
            syn <= '0;
        end else if (shift_en) begin
            syn <= {syn[1], syn[0] ^ syn[2], bit_in ^ syn[2]};
        end
    end

endmodule

// File: rtl/cyclic74_decoder.sv
// Serial (7,4) cyclic-code decoder with single-error correction.
// Accepts one codeword bit per handshake (r6 first), divides by g(x),
// corrects at most one bit and presents the result on a valid/ready port.
//   clk       : clock, rising edge
//   rst       : synchronous active-low reset
//   in_valid  : in_bit valid this cycle
//   in_bit    : received codeword bit
//   in_ready  : decoder accepts a bit this cycle
//   out_valid : decoded result available
//   out_ready : consumer takes the result
//   msg       : corrected message, msg[j] = c[j+3]
//   syndrome  : raw syndrome {s2,s1,s0}
//   err_det   : syndrome nonzero
//   err_pos   : corrected bit position, 0 when err_det = 0
module cyclic74_decoder
    import cyclic74_pkg::*;
#(
    parameter int unsigned N     = cyclic74_pkg::N,
    parameter int unsigned K     = cyclic74_pkg::K,
    parameter logic [3:0]  GPOLY = cyclic74_pkg::GPOLY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] msg,
    output logic [2:0] syndrome,
    output logic       err_det,
    output logic [2:0] err_pos
);

    if (N != 7 || K != 4 || GPOLY != 4'b1011) begin : g_param_check
        $error("cyclic74_decoder supports only N=7, K=4, GPOLY=4'b1011");
    end

    state_t     state_q, state_d;
    logic [2:0] cnt_q;
    logic [6:0] rx_q;
    logic [2:0] syn;
    logic       accept;
    logic       syn_clear;
    logic       load_out;
    logic [2:0] pos;
    logic [6:0] flip_mask;
    logic [6:0] corrected;

    cyclic74_syndrome_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .clear    (syn_clear),
        .shift_en (accept),
        .bit_in   (in_bit),
        .syn      (syn)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        accept    = 1'b0;
        syn_clear = 1'b0;
        load_out  = 1'b0;
        case (state_q)
            RX: begin
                // Gate with rst so in_ready is low for the whole reset cycle.
                in_ready = rst;
                accept   = in_valid & rst;
                if (accept && cnt_q == 3'd6) begin
                    state_d = CORR;
                end
            end
            CORR: begin
                load_out = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    syn_clear = 1'b1;
                    state_d   = RX;
                end
            end
            default: state_d = RX;
        endcase
    end

    // Bit i of rx_q holds r_i once all seven bits are in.
    always_comb begin
        pos       = syn2pos(syn);
        flip_mask = (syn != 3'b000) ? (7'd1 << pos) : '0;
        corrected = rx_q ^ flip_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RX;
            cnt_q     <= '0;
            rx_q      <= '0;
            out_valid <= 1'b0;
            msg       <= '0;
            syndrome  <= '0;
            err_det   <= 1'b0;
            err_pos   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rx_q  <= {rx_q[5:0], in_bit};
                cnt_q <= (cnt_q == 3'd6) ? 3'd0 : cnt_q + 3'd1;
            end
            if (load_out) begin
                out_valid <= 1'b1;
                msg       <= corrected[6:3];
                syndrome  <= syn;
                err_det   <= (syn != 3'b000);
                err_pos   <= pos;
            end else if (state_q == OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cyclic74_decoder.sv
// Scoreboard bench for cyclic74_decoder: the driver pushes hand-computed
// results, a negedge monitor pops and compares at each output handshake.
module tb_cyclic74_decoder;

    typedef struct packed {
        logic [3:0] msg;
        logic [2:0] syn;
        logic       det;
        logic [2:0] pos;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] msg;
    logic [2:0] syndrome;
    logic       err_det;
    logic [2:0] err_pos;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    // Syndrome of a single error at position i: x^i mod g(x).
    logic [2:0] syn_tab [0:6] = '{3'b001, 3'b010, 3'b100, 3'b011,
                                  3'b110, 3'b111, 3'b101};

    always #5 clk = ~clk;

    cyclic74_decoder #(.N(7), .K(4), .GPOLY(4'b1011)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .msg       (msg),
        .syndrome  (syndrome),
        .err_det   (err_det),
        .err_pos   (err_pos)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Monitor: in_ready must be low whenever a result is held, the result
    // must not move while stalled, and it is scored when out_ready is high.
    exp_t held;
    bit   held_vld = 1'b0;
    always @(negedge clk) begin
        exp_t cur, e;
        cur = '{msg: msg, syn: syndrome, det: err_det, pos: err_pos};
        if (rst && out_valid) begin
            chk("in_ready_low_in_out", {31'd0, in_ready}, 32'd0);
            if (!out_ready) begin
                if (held_vld) chk("hold_stable", {21'd0, cur}, {21'd0, held});
                held     = cur;
                held_vld = 1'b1;
            end else begin
                held_vld = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("msg",      {28'd0, msg},      {28'd0, e.msg});
                    chk("syndrome", {29'd0, syndrome}, {29'd0, e.syn});
                    chk("err_det",  {31'd0, err_det},  {31'd0, e.det});
                    chk("err_pos",  {29'd0, err_pos},  {29'd0, e.pos});
                end
            end
        end else begin
            held_vld = 1'b0;
        end
    end

    // Sends cw[6] first; each bit waits (bounded) for in_ready.
    task automatic send_bits(input logic [6:0] cw, input int nbits, input bit gaps);
        bit ok;
        for (int i = 6; i > 6 - nbits; i--) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_bit   = cw[i];
            ok = 1'b0;
            for (int t = 0; t < 40 && !ok; t++) begin
                @(negedge clk);
                if (in_ready) ok = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!ok) chk("accept_timeout", 32'd1, 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [6:0] cw, input bit gaps, input exp_t e);
        exp_q.push_back(e);
        send_bits(cw, 7, gaps);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_outs"}, {21'd0, msg, syndrome, err_det, err_pos}, 32'd0);
    endtask

    initial begin
        logic [6:0] cw;
        bit ok;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // 1: clean frame, plus output latency from the r0-accept edge
        send_frame(7'b0001011, 1'b0, '{4'b0001, 3'b000, 1'b0, 3'd0});
        chk("latency_edge1_out_valid", {31'd0, out_valid}, 32'd0);
        chk("corr_in_ready",           {31'd0, in_ready},  32'd0);
        @(posedge clk);
        #1;
        chk("latency_edge2_out_valid", {31'd0, out_valid}, 32'd1);
        wait_drain();

        // 2: single errors at c5 and c1
        send_frame(7'b0101011, 1'b0, '{4'b0001, 3'b111, 1'b1, 3'd5});
        wait_drain();
        send_frame(7'b0001001, 1'b0, '{4'b0001, 3'b010, 1'b1, 3'd1});
        wait_drain();

        // 3: all-ones codeword and its single-error sweep
        send_frame(7'b1111111, 1'b0, '{4'b1111, 3'b000, 1'b0, 3'd0});
        wait_drain();
        for (int p = 0; p < 7; p++) begin
            cw = 7'b1111111 ^ (7'd1 << p);
            send_frame(cw, 1'b0, '{4'b1111, syn_tab[p], 1'b1, 3'(p)});
            wait_drain();
        end

        // 4: double error c0,c1 miscorrects to position 3
        send_frame(7'b0001000, 1'b0, '{4'b0000, 3'b011, 1'b1, 3'd3});
        wait_drain();

        // 5: input gaps, 5-cycle output stall, back-to-back second frame
        out_ready = 1'b0;
        send_frame(7'b0101011, 1'b1, '{4'b0001, 3'b111, 1'b1, 3'd5});
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) chk("out_valid_timeout", 32'd1, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_frame(7'b0001011, 1'b1, '{4'b0001, 3'b000, 1'b0, 3'd0});
        wait_drain();

        // 6: reset after 4 bits, then a clean frame
        send_bits(7'b0101011, 4, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("midframe_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_frame(7'b0001011, 1'b0, '{4'b0001, 3'b000, 1'b0, 3'd0});
        wait_drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
